acc6_result_drain: RTL and testbench
====================================

# acc6_result_drain

Downstream stage of the six-lane floating-point accumulator. Captures each 192-bit accumulated result (six 32-bit FP lanes) on the accumulator's `valid` pulse, buffers up to `DEPTH` results, and serialises them as a 32-bit AXI-Stream, lane 0 first, with `tlast` on lane 5. The accumulator has no backpressure, so this block absorbs the stall of the output interface. When its buffer is full it drops results and flags overflow.

## Interface
Parameters:
- `DEPTH`, 4: number of 192-bit result slots; power of two, 2..16.
- `LANES`, 6: 32-bit lanes per result; fixed at 6 for this block.

Ports:
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: reset; synchronous, active-high.
- `acc_valid`, input, 1: one-cycle pulse; the result on `acc_data` is valid this cycle.
- `acc_data`, input, 192: lane k is `[32k+31:32k]`.
- `m_tdata`, output, 32: current output lane word.
- `m_tvalid`, output, 1: `m_tdata` is valid.
- `m_tready`, input, 1: downstream accepts the word.
- `m_tlast`, output, 1: high with lane 5 of each result.
- `level`, output, `$clog2(DEPTH+1)`: number of results held, including the one being drained.
- `ovf`, output, 1: sticky; set when a result is dropped.
- `ovf_clr`, input, 1: clears `ovf`.

## Operation
- Push: when `acc_valid` is high and a slot is free, the full 192 bits are written to the FIFO tail.
- Full condition: `level == DEPTH` at the clock edge.
  - If the FIFO is full and the head's lane 5 transfers in the same cycle, the push is accepted and `level` is unchanged.
  - Otherwise the result is discarded, `ovf` is set and `level` is unchanged.
- Drain: the head entry is presented one lane at a time. A 3-bit lane counter runs 0..5.
  - `m_tdata` = head lane[`lane`].
  - `m_tlast` = (`lane` == 5) && `m_tvalid`.
- A transfer occurs when `m_tvalid && m_tready`. On a transfer:
  - `lane` increments.
  - At lane 5 the counter wraps to 0, the head pops and `level` decrements, unless a push is accepted in the same cycle.
- `m_tvalid` = (`level` != 0). Once high it stays high until the transfer that completes the last lane of the last result.
- AXI-Stream rules:
  - `m_tdata` and `m_tlast` are stable while `m_tvalid && !m_tready`.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Overflow flag:
  - `ovf_clr` clears `ovf` on the next edge.
  - If a drop and `ovf_clr` occur in the same cycle, set wins.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is a separate counter: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- No data reordering or arithmetic. Lane words pass bit-exact.

## Timing
- Reset values, applied at the edge with `rst` high:
  - `m_tvalid` = 0, `m_tlast` = 0, `level` = 0, `ovf` = 0.
  - `lane` = 0; read and write pointers = 0.
  - `m_tdata` = 0. FIFO contents are don't-care.
- Reset mid-drain discards all buffered results and any partially sent result. No `tlast` is emitted for the truncated result.
- Latency: `acc_valid` at edge t into an empty FIFO gives `m_tvalid` = 1 with lane 0 in the cycle after t.
- Throughput:
  - One lane per cycle when `m_tready` is held high, i.e. 6 cycles per result.
  - Back-to-back results drain with no bubble: lane 0 of the next result follows lane 5 of the previous one directly.
- An `acc_valid` arriving in the same cycle `rst` is high is ignored.
- `level` and `ovf` are registered outputs, updated one edge after the causing event.

## Structure
- Package `acc6_pkg` holds:
  - Constants `LANES` = 6, `WORD_W` = 32, `VEC_W` = 192.
  - Typedef `lane_idx_t` (3 bits).
- Sub-module `result_fifo192`: a synchronous FIFO of width `VEC_W` and depth `DEPTH`, with registered read data and a combinational `full`/`empty`.
- The lane mux, lane counter, overflow logic and AXI-Stream output live in `acc6_result_drain`.

## Test plan
- Single result: pulse `acc_valid` with lanes = 0x3F800000, 0x40000000, …, 0x40C00000 (1.0 to 6.0), `m_tready` = 1.
  - Expect six words in order starting the cycle after the pulse.
  - `m_tlast` is high only on 0x40C00000; `level` returns 0.
- Backpressure: same stimulus, with `m_tready` toggling 1,0,0,1,….
  - Data and `tlast` hold while stalled.
  - Exactly 6 transfers occur with no duplicates.
- Fill to overflow: with `DEPTH` = 4 and `m_tready` = 0, send 5 results.
  - `level` = 4 and `ovf` = 1; the 5th result is absent.
  - Releasing `m_tready` yields 24 words and 4 `tlast` pulses.
- Full plus simultaneous pop: with the FIFO full, push in the same cycle lane 5 transfers.
  - Push accepted; `ovf` stays 0; `level` stays 4.
- Overflow clear race: assert `ovf_clr` in the cycle a drop occurs.
  - `ovf` = 1 afterwards; a later lone `ovf_clr` gives `ovf` = 0.
- Reset mid-drain: assert `rst` after lane 2 of a result with 2 more queued.
  - The next cycle shows `m_tvalid` = 0 and `level` = 0.
  - A fresh result then drains from lane 0.

Source files
------------

// File: rtl/acc6_pkg.sv
// Shared constants and types for the six-lane accumulator result path.
package acc6_pkg;

    localparam int LANES  = 6;
    localparam int WORD_W = 32;
    localparam int VEC_W  = LANES * WORD_W;

    typedef logic [2:0] lane_idx_t;

endpackage

// File: rtl/result_fifo192.sv
// Synchronous FIFO of full accumulator results with a registered head word
// that already holds the next entry, so a push into an empty FIFO is visible
// on the following cycle.
module result_fifo192
    import acc6_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [VEC_W-1:0]             wr_data,
    output logic [VEC_W-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [VEC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    head_next;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    // NOTE: the storage array has no reset; its contents are don't-care until
    // written, and leaving it out keeps it mappable to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Bypass when the slot being written becomes the new head.
            rd_data <= (push && (wr_ptr == head_next)) ? wr_data : mem[head_next];
        end
    end

endmodule

// File: rtl/acc6_result_drain.sv
// Buffers accumulator results and drains them lane by lane as a 32-bit
// AXI-Stream with tlast on the final lane; drops and flags overflow when full.
module acc6_result_drain
    import acc6_pkg::WORD_W, acc6_pkg::VEC_W, acc6_pkg::lane_idx_t;
#(
    parameter int DEPTH = 4,
    parameter int LANES = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         acc_valid,
    input  logic [VEC_W-1:0]             acc_data,
    output logic [WORD_W-1:0]            m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf,
    input  logic                         ovf_clr
);

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

    logic [VEC_W-1:0] head;
    logic             full;
    logic             empty;
    logic             xfer;
    logic             last_xfer;
    logic             push;
    logic             drop;
    lane_idx_t        lane;

    assign m_tvalid  = !empty;
    assign xfer      = m_tvalid && m_tready;
    assign last_xfer = xfer && (lane == LAST_LANE);
    // A full FIFO still takes a result when the head leaves in the same cycle.
    assign push      = acc_valid && (!full || last_xfer);
    assign drop      = acc_valid && !push;
    assign m_tlast   = m_tvalid && (lane == LAST_LANE);

    result_fifo192 #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (last_xfer),
        .wr_data (acc_data),
        .rd_data (head),
        .count   (level),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: every output of this block gets a default first, so no latch can
    // be inferred for lane values the counter never reaches.
    always_comb begin
        m_tdata = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane == lane_idx_t'(k)) begin
                m_tdata = head[k*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane <= '0;
            ovf  <= 1'b0;
        end else begin
            if (xfer) begin
                lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc6_result_drain.sv
// Self-checking bench for acc6_result_drain: table-driven single results,
// scripted fill/overflow/reset sequences, and a word-level scoreboard.
module tb_acc6_result_drain;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        logic [31:0] w [6];
        logic [3:0]  pat;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         acc_valid;
    logic [191:0] acc_data;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic [2:0]   level;
    logic         ovf;
    logic         ovf_clr;

    int    total = 0;
    int    bad   = 0;
    word_t q[$];
    bit    m_ovf = 1'b0;
    int    xfers;
    int    lasts;
    bit    seen_first;
    logic [31:0] first_word;
    logic [31:0] last_word;

    always #5 clk = ~clk;

    acc6_result_drain #(.DEPTH(DEPTH), .LANES(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_valid (acc_valid),
        .acc_data  (acc_data),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] mk(input int r);
        logic [191:0] v;
        for (int k = 0; k < 6; k++) v[k*32 +: 32] = (32'(r) << 24) | 32'h00A0_0000 | 32'(k);
        return v;
    endfunction

    // Check outputs against the scoreboard at the falling edge, advance the
    // model with the inputs that the next rising edge will sample.
    task automatic step();
        bit exp_valid;
        bit pop_now;
        int lvl;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        lvl = (q.size() + 5) / 6;
        check("tvalid", m_tvalid, exp_valid);
        if (exp_valid) begin
            check("tdata", m_tdata, q[0].data);
            check("tlast", m_tlast, q[0].last);
        end else begin
            check("tlast_idle", m_tlast, 1'b0);
        end
        check("level", level, lvl);
        check("ovf", ovf, m_ovf);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            pop_now = exp_valid && m_tready && q[0].last;
            if (exp_valid && m_tready) begin
                xfers++;
                if (q[0].last) lasts++;
                if (!seen_first) begin
                    first_word = q[0].data;
                    seen_first = 1'b1;
                end
                last_word = q[0].data;
                void'(q.pop_front());
            end
            if (acc_valid && (lvl < DEPTH || pop_now)) begin
                for (int k = 0; k < 6; k++) q.push_back('{acc_data[k*32 +: 32], k == 5});
            end else if (acc_valid) begin
                m_ovf = 1'b1;
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_result(input logic [191:0] d);
        acc_valid = 1'b1;
        acc_data  = d;
        step();
        acc_valid = 1'b0;
    endtask

    task automatic clear_stats();
        xfers = 0;
        lasts = 0;
        seen_first = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        m_tready = 1'b1;
        for (int i = 0; i < max_cycles && q.size() != 0; i++) step();
        check("drain_timeout", q.size(), 0);
        step();
    endtask

    initial begin
        vec_t tbl [4];
        logic [191:0] d;

        tbl[0] = '{'{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000},
                   4'b1111, 32'h3F800000, 32'h40C00000};
        tbl[1] = '{'{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000},
                   4'b1001, 32'h3F800000, 32'h40C00000};
        tbl[2] = '{'{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hCAFEF00D},
                   4'b0101, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[3] = '{'{32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'hAAAA5555},
                   4'b0011, 32'hFFFFFFFF, 32'hAAAA5555};

        rst = 1'b1; acc_valid = 1'b0; acc_data = '0; m_tready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tdata", m_tdata, 32'h0);
        check("reset_level", level, 0);
        step();

        // Single results under several ready patterns.
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 6; k++) d[k*32 +: 32] = tbl[t].w[k];
            clear_stats();
            m_tready = 1'b0;
            push_result(d);
            for (int i = 0; i < 60 && q.size() != 0; i++) begin
                m_tready = tbl[t].pat[i % 4];
                step();
            end
            check("vec_timeout", q.size(), 0);
            m_tready = 1'b1;
            step();
            check("vec_xfers", xfers, 6);
            check("vec_lasts", lasts, 1);
            check("vec_first", first_word, tbl[t].exp_first);
            check("vec_last", last_word, tbl[t].exp_last);
            check("vec_level", level, 0);
        end

        // Fill past capacity with the output stalled.
        m_tready = 1'b0;
        for (int r = 0; r < 5; r++) push_result(mk(r));
        step();
        check("fill_level", level, 4);
        check("fill_ovf", ovf, 1'b1);
        clear_stats();
        drain(100);
        check("fill_xfers", xfers, 24);
        check("fill_lasts", lasts, 4);
        check("fill_last_word", last_word, 32'h03A00005);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        step();
        check("ovf_cleared", ovf, 1'b0);

        // Full FIFO plus a push in the cycle the head's last lane leaves.
        m_tready = 1'b0;
        for (int r = 0; r < 4; r++) push_result(mk(8 + r));
        m_tready = 1'b1;
        repeat (5) step();
        check("pre_pop_tlast", m_tlast, 1'b1);
        push_result(mk(12));
        check("full_pop_ovf", ovf, 1'b0);
        check("full_pop_level", level, 4);
        drain(100);

        // Drop and clear in the same cycle: the drop wins.
        m_tready = 1'b0;
        for (int r = 0; r < 4; r++) push_result(mk(16 + r));
        ovf_clr = 1'b1;
        push_result(mk(20));
        ovf_clr = 1'b0;
        check("race_ovf", ovf, 1'b1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("race_clr", ovf, 1'b0);
        drain(100);

        // Reset in the middle of a result, with more queued behind it.
        m_tready = 1'b0;
        for (int r = 0; r < 3; r++) push_result(mk(24 + r));
        m_tready = 1'b1;
        repeat (3) step();
        m_tready = 1'b0;
        rst = 1'b1;
        acc_valid = 1'b1;
        acc_data = mk(30);
        step();
        rst = 1'b0;
        acc_valid = 1'b0;
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_level", level, 0);
        clear_stats();
        push_result(mk(31));
        drain(40);
        check("post_rst_first", first_word, 32'h1FA00000);
        check("post_rst_lasts", lasts, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
